nios2_mult_pipe: RTL and testbench

NIOS2_MULT_PIPE -- requirements
Module: nios2_mult_pipe

---
 rtl/nios2_mult_pkg.sv | 45 ++++
 rtl/nios2_mult_pp.sv | 34 +++
 rtl/nios2_mult_pipe.sv | 175 +++++++++++++++++
 tb/tb_nios2_mult_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_mult_pkg.sv
// -----------------------------------------------------------------------------
// nios2_mult_pkg
// Shared definitions for the pipelined Nios II multiplier: the operation
// encoding, the fixed pipeline latency, and small helpers that decode the
// operand signedness and the result half from an operation.
// -----------------------------------------------------------------------------
package nios2_mult_pkg;

    // Operation encoding as it arrives on in_op.
    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,  // low half, signedness irrelevant
        OP_MULXSS = 2'd1,  // high half, signed x signed
        OP_MULXSU = 2'd2,  // high half, signed x unsigned
        OP_MULXUU = 2'd3   // high half, unsigned x unsigned
    } mult_op_e;

    // Edges from acceptance to a visible result (one per register stage).
    localparam int LATENCY = 3;

    // True when src1 is treated as a signed value.
    function automatic logic src1_signed(input mult_op_e op);
        case (op)
            OP_MULXSS: src1_signed = 1'b1;
            OP_MULXSU: src1_signed = 1'b1;
            default:   src1_signed = 1'b0;
        endcase
    endfunction

    // True when src2 is treated as a signed value.
    function automatic logic src2_signed(input mult_op_e op);
        case (op)
            OP_MULXSS: src2_signed = 1'b1;
            default:   src2_signed = 1'b0;
        endcase
    endfunction

    // True when the upper half of the double-width product is returned.
    function automatic logic high_half(input mult_op_e op);
        case (op)
            OP_MUL:  high_half = 1'b0;
            default: high_half = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nios2_mult_pp.sv
// -----------------------------------------------------------------------------
// nios2_mult_pp
// Registered signed partial-product multiplier. Operands are W-bit signed; the
// 2*W-bit product is captured when en is high and held otherwise.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high clear of the product register
//   en     - capture enable (low holds the current product)
//   a, b   - W-bit signed operands
//   p      - registered 2*W-bit signed product
// -----------------------------------------------------------------------------
module nios2_mult_pp #(
    parameter int W = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    // Product register: both operands are signed, so the multiply sign-extends
    // them to the full 2*W result width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= {(2*W){1'b0}};
        end else if (en) begin
            p <= a * b;
        end
    end

endmodule

// File: rtl/nios2_mult_pipe.sv
// -----------------------------------------------------------------------------
// nios2_mult_pipe
// Three-stage pipelined multiplier for the Nios II MUL / MULXSS / MULXSU /
// MULXUU instructions with a valid/ready handshake and a sideband tag.
//   S1: operands, op and tag
//   S2: four half-width partial products (LL, LH, HL, HH); the upper halves
//       carry an extra sign bit so signed and unsigned operands share one path
//   S3: summed double-width product, selected half and tag
// All stages move together only when the output can advance; flush clears
// every stage valid bit at the next edge and leaves the data registers alone.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - request handshake (in_ready = advance)
//   in_op                 - operation select (nios2_mult_pkg::mult_op_e)
//   in_src1, in_src2      - multiplicand, multiplier
//   in_tag                - sideband value returned with the result
//   flush                 - drop all in-flight requests
//   out_valid/out_ready   - result handshake
//   out_result, out_tag   - selected product half and its tag
// -----------------------------------------------------------------------------
module nios2_mult_pipe
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int H   = DATA_W / 2;   // half-operand width
    localparam int PW  = H + 1;        // partial-product operand width (with sign)
    localparam int FW  = 2 * DATA_W;   // full product width
    localparam int EXT = FW - 2 * PW;  // sign-extension bits per partial product

    logic advance_s;
    logic data_en_s;
    logic load1_s;

    // Stage 1 registers
    logic              v1_r;
    mult_op_e          op1_r;
    logic [DATA_W-1:0] a1_r;
    logic [DATA_W-1:0] b1_r;
    logic [TAG_W-1:0]  tag1_r;

    // Stage 2 registers (partial products live inside the pp instances)
    logic              v2_r;
    mult_op_e          op2_r;
    logic [TAG_W-1:0]  tag2_r;

    logic signed [PW-1:0]   a_lo_s, a_hi_s, b_lo_s, b_hi_s;
    logic signed [2*PW-1:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
    logic [FW-1:0]          ll_x_s, lh_x_s, hl_x_s, hh_x_s, full_s;
    logic [DATA_W-1:0]      result_s;

    // The whole pipe moves only when the output register is free or draining.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;
    // Data registers hold during a flush; only the valid bits are cleared.
    assign data_en_s = advance_s && !flush;
    // S1 data loads only for a real request so an idle in_op never enters state.
    assign load1_s   = data_en_s && in_valid;

    // Stage 1: capture the accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r   <= 1'b0;
            op1_r  <= OP_MUL;
            a1_r   <= {DATA_W{1'b0}};
            b1_r   <= {DATA_W{1'b0}};
            tag1_r <= {TAG_W{1'b0}};
        end else begin
            if (flush) begin
                v1_r <= 1'b0;
            end else if (advance_s) begin
                v1_r <= in_valid;
            end
            if (load1_s) begin
                op1_r  <= mult_op_e'(in_op);
                a1_r   <= in_src1;
                b1_r   <= in_src2;
                tag1_r <= in_tag;
            end
        end
    end

    // Split operands into halves. Low halves are always unsigned; a high half
    // gets its top bit replicated only when that operand is signed, which is the
    // sign correction that lets one signed multiplier cover all three modes.
    always_comb begin
        a_lo_s = {1'b0, a1_r[H-1:0]};
        b_lo_s = {1'b0, b1_r[H-1:0]};
        a_hi_s = {src1_signed(op1_r) & a1_r[DATA_W-1], a1_r[DATA_W-1:H]};
        b_hi_s = {src2_signed(op1_r) & b1_r[DATA_W-1], b1_r[DATA_W-1:H]};
    end

    nios2_mult_pp #(.W(PW)) u_pp_ll (
        .clk(clk), .reset(reset), .en(data_en_s), .a(a_lo_s), .b(b_lo_s), .p(pp_ll_s)
    );
    nios2_mult_pp #(.W(PW)) u_pp_lh (
        .clk(clk), .reset(reset), .en(data_en_s), .a(a_lo_s), .b(b_hi_s), .p(pp_lh_s)
    );
    nios2_mult_pp #(.W(PW)) u_pp_hl (
        .clk(clk), .reset(reset), .en(data_en_s), .a(a_hi_s), .b(b_lo_s), .p(pp_hl_s)
    );
    nios2_mult_pp #(.W(PW)) u_pp_hh (
        .clk(clk), .reset(reset), .en(data_en_s), .a(a_hi_s), .b(b_hi_s), .p(pp_hh_s)
    );

    // Stage 2: control and tag travel alongside the partial products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_r   <= 1'b0;
            op2_r  <= OP_MUL;
            tag2_r <= {TAG_W{1'b0}};
        end else begin
            if (flush) begin
                v2_r <= 1'b0;
            end else if (advance_s) begin
                v2_r <= v1_r;
            end
            if (data_en_s) begin
                op2_r  <= op1_r;
                tag2_r <= tag1_r;
            end
        end
    end

    // Sum the sign-extended partial products modulo 2^FW and pick the half.
    always_comb begin
        ll_x_s = {{EXT{pp_ll_s[2*PW-1]}}, pp_ll_s};
        lh_x_s = {{EXT{pp_lh_s[2*PW-1]}}, pp_lh_s};
        hl_x_s = {{EXT{pp_hl_s[2*PW-1]}}, pp_hl_s};
        hh_x_s = {{EXT{pp_hh_s[2*PW-1]}}, pp_hh_s};
        full_s = (hh_x_s << (2 * H)) + ((lh_x_s + hl_x_s) << H) + ll_x_s;
        if (high_half(op2_r)) begin
            result_s = full_s[FW-1:DATA_W];
        end else begin
            result_s = full_s[DATA_W-1:0];
        end
    end

    // Stage 3: registered result and tag presented to the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= {DATA_W{1'b0}};
            out_tag    <= {TAG_W{1'b0}};
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance_s) begin
                out_valid <= v2_r;
            end
            if (data_en_s) begin
                out_result <= result_s;
                out_tag    <= tag2_r;
            end
        end
    end

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_nios2_mult_pipe
// Directed scoreboard bench: issuing a request pushes its hand-computed result
// into a queue; monitors pop and compare whenever a result is consumed. A
// 32-bit and a 16-bit instance are exercised.
// -----------------------------------------------------------------------------
module tb_nios2_mult_pipe;
    import nios2_mult_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;

    logic        n_valid, n_ready, n_out_valid, n_out_ready;
    logic [1:0]  n_op;
    logic [15:0] n_src1, n_src2, n_out_result;
    logic [4:0]  n_tag, n_out_tag;

    exp_t sb32[$];
    exp_t sb16[$];
    exp_t m32_e;
    exp_t m16_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    nios2_mult_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    nios2_mult_pipe #(.DATA_W(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(n_valid), .in_ready(n_ready),
        .in_op(n_op), .in_src1(n_src1), .in_src2(n_src2), .in_tag(n_tag),
        .flush(flush), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_result(n_out_result), .out_tag(n_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // 32-bit monitor: compare every consumed result against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out32 got=%0h tag=%0d want=none", out_result, out_tag);
            end else begin
                m32_e = sb32.pop_front();
                check("result32", {32'd0, out_result}, {32'd0, m32_e.res});
                check("tag32", {59'd0, out_tag}, {59'd0, m32_e.tag});
                if (m32_e.lat) check("latency32", 64'(cyc), 64'(m32_e.acc + LATENCY));
            end
        end
    end

    // 16-bit monitor.
    always @(negedge clk) begin
        if (!reset && n_out_valid && n_out_ready) begin
            if (sb16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out16 got=%0h want=none", n_out_result);
            end else begin
                m16_e = sb16.pop_front();
                check("result16", {48'd0, n_out_result}, {48'd0, m16_e.res[15:0]});
                check("tag16", {59'd0, n_out_tag}, {59'd0, m16_e.tag});
                if (m16_e.lat) check("latency16", 64'(cyc), 64'(m16_e.acc + LATENCY));
            end
        end
    end

    // Present one request (called at posedge+1) and hold it until accepted.
    task automatic issue(input bit narrow, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res,
                         input bit push, input bit lat);
        bit done;
        done = 1'b0;
        if (narrow) begin
            n_valid = 1'b1; n_op = op; n_src1 = a[15:0]; n_src2 = b[15:0]; n_tag = tag;
        end else begin
            in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((narrow ? n_ready : in_ready) == 1'b1) begin
                done = 1'b1;
                if (push) begin
                    if (narrow) sb16.push_back('{res, tag, cyc, lat});
                    else        sb32.push_back('{res, tag, cyc, lat});
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_valid  = 1'b0;
        in_op    = 2'd3;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout tag=%0d got=not_accepted want=accepted", tag);
        end
    endtask

    // Wait (bounded) for both scoreboards to empty.
    task automatic drain();
        for (int i = 0; i < 30 && (sb32.size() != 0 || sb16.size() != 0); i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(sb32.size() + sb16.size()), 64'd0);
    endtask

    // Count out_valid cycles over a window; none are expected.
    task automatic quiet_window(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(name, 64'(seen), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_op = 2'd0; in_src1 = 32'd0; in_src2 = 32'd0; in_tag = 5'd0;
        out_ready = 1'b1;
        n_valid = 1'b0; n_op = 2'd0; n_src1 = 16'd0; n_src2 = 16'd0; n_tag = 5'd0;
        n_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic MUL with latency
        issue(1'b0, OP_MUL, 32'h00010003, 32'h00020005, 5'd7, 32'h000B000F, 1'b1, 1'b1);
        drain();

        // Signed/unsigned high halves, back to back
        issue(1'b0, OP_MULXSS, 32'hFFFFFFFF, 32'h00000002, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1);
        issue(1'b0, OP_MULXSU, 32'hFFFFFFFF, 32'h00000002, 5'd2, 32'hFFFFFFFF, 1'b1, 1'b1);
        issue(1'b0, OP_MULXUU, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'h00000001, 1'b1, 1'b1);
        issue(1'b0, OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000, 1'b1, 1'b1);
        issue(1'b0, OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b1);
        drain();

        // Backpressure: first result stalled for two cycles
        out_ready = 1'b0;
        fork
            begin
                issue(1'b0, OP_MUL,    32'd3,        32'd5, 5'd1, 32'd15,        1'b1, 1'b0);
                issue(1'b0, OP_MUL,    32'd7,        32'd9, 5'd2, 32'd63,        1'b1, 1'b0);
                issue(1'b0, OP_MULXSU, 32'h80000000, 32'd2, 5'd3, 32'hFFFFFFFF,  1'b1, 1'b0);
                issue(1'b0, OP_MULXUU, 32'h80000000, 32'd2, 5'd4, 32'h00000001,  1'b1, 1'b0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                check("stall_first_valid", {63'd0, seen}, 64'd1);
                check("stall_in_ready_a", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_b", {63'd0, in_ready}, 64'd0);
                check("stall_hold_result", {32'd0, out_result}, 64'd15);
                check("stall_hold_tag", {59'd0, out_tag}, 64'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("stall_release_ready", {63'd0, in_ready}, 64'd1);
            end
        join
        drain();

        // Flush one cycle after two acceptances, a third accepted with the flush
        issue(1'b0, OP_MUL, 32'd11, 32'd2, 5'd10, 32'd22, 1'b0, 1'b0);
        issue(1'b0, OP_MUL, 32'd12, 32'd2, 5'd11, 32'd24, 1'b0, 1'b0);
        flush = 1'b1;
        issue(1'b0, OP_MUL, 32'd13, 32'd2, 5'd12, 32'd26, 1'b0, 1'b0);
        flush = 1'b0;
        quiet_window("flush_no_output", 6);
        issue(1'b0, OP_MUL, 32'd100, 32'd3, 5'd13, 32'd300, 1'b1, 1'b1);
        drain();

        // Reset with three requests in flight
        issue(1'b0, OP_MULXUU, 32'hFFFFFFFF, 32'd2, 5'd20, 32'd1, 1'b0, 1'b0);
        issue(1'b0, OP_MUL,    32'd6,        32'd7, 5'd21, 32'd42, 1'b0, 1'b0);
        issue(1'b0, OP_MUL,    32'd8,        32'd9, 5'd22, 32'd72, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_result", {32'd0, out_result}, 64'd0);
        check("midrst_out_tag", {59'd0, out_tag}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        quiet_window("post_reset_no_output", 8);

        // 16-bit instance
        issue(1'b1, OP_MULXUU, 32'h0000FFFF, 32'h0000FFFF, 5'd3, 32'h0000FFFE, 1'b1, 1'b1);
        issue(1'b1, OP_MUL,    32'h0000FFFF, 32'h0000FFFF, 5'd4, 32'h00000001, 1'b1, 1'b1);
        issue(1'b1, OP_MULXSS, 32'h0000FFFF, 32'h0000FFFF, 5'd5, 32'h00000000, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
